fifo_ctrl: RTL and testbench
============================

# fifo_ctrl

Sequencing controller that turns the 8-entry × 32-bit register file into a synchronous first-in/first-out queue. It owns the head/tail pointers, occupancy count and status flags. It drives the register file's write-enable, write address, write data and read address, and registers the read data toward the consumer. It sits between a producer/consumer pair and a single `Register_file` instance at the top of the FIFO block.

## Interface
- No parameters; depth fixed at 8, data width fixed at 32.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset_n`  in  1  synchronous, active-high reset; `reset_n`=1 at a rising edge resets the block.
- `wr_en`  in  1  push request.
- `din`  in  32  push data.
- `rd_en`  in  1  pop request.
- `dout`  out  32  registered pop data.
- `data_count`  out  4  occupancy, 0..8.
- `full`  out  1  `data_count`==8.
- `empty`  out  1  `data_count`==0.
- `wr_ack`  out  1  previous-cycle push accepted.
- `wr_err`  out  1  previous-cycle push rejected (full).
- `rd_ack`  out  1  previous-cycle pop accepted; `dout` valid.
- `rd_err`  out  1  previous-cycle pop rejected (empty).
- `rf_we`  out  1  register file write enable.
- `rf_wAddr`  out  3  register file write address (= tail).
- `rf_wData`  out  32  register file write data (= `din`).
- `rf_rAddr`  out  3  register file read address (= head).
- `rf_rData`  in  32  register file combinational read data.

## Operation
- State: `head`[2:0], `tail`[2:0], `count`[3:0], and a 3-bit op-state register with states IDLE, WRITE, READ, WR_RD, WR_ERR, RD_ERR.
- Acceptance is decided from the current, pre-edge `count`:
  - push_ok = `wr_en` & (`count`<8).
  - pop_ok = `rd_en` & (`count`>0).
- `rf_we` = push_ok & ~`reset_n`, combinational. `rf_wAddr`=`tail`, `rf_rAddr`=`head`, `rf_wData`=`din`, all combinational.
- On push_ok: the entry is written at `tail` on the same edge, and `tail`←`tail`+1, wrapping 7→0.
- On pop_ok: `dout`←`rf_rData` (the entry at `head`), and `head`←`head`+1, wrapping 7→0.
- Count update: `count`←`count` + push_ok − pop_ok.
  - Push and pop together with 0<`count`<8: both performed, count unchanged.
  - Push and pop together when empty: push performed; pop rejected, so `rd_err`=1. No write-through bypass.
  - Push and pop together when full: pop performed; push rejected, so `wr_err`=1.
- Next op-state, evaluated by priority:
  1. push_ok & pop_ok → WR_RD.
  2. push_ok & `rd_en` & ~pop_ok → WRITE, with `rd_err` also set.
  3. pop_ok & `wr_en` & ~push_ok → READ, with `wr_err` also set.
  4. push_ok → WRITE.
  5. pop_ok → READ.
  6. `wr_en` rejected → WR_ERR.
  7. `rd_en` rejected → RD_ERR.
  8. Otherwise IDLE.
- The ack and err outputs are registered, each asserted for exactly one cycle per request. `wr_ack` and `wr_err` are never both 1; `rd_ack` and `rd_err` are never both 1.
- `dout` holds its last value when no pop is accepted.

## Timing
- Reset values: `head`=`tail`=0, `count`=0, `empty`=1, `full`=0, `dout`=0, all ack/err=0, op-state IDLE.
- Reset has priority over `wr_en`/`rd_en`. No write reaches the register file during a reset cycle.
- Reset mid-stream discards contents: pointers return to 0. Register file contents are not cleared but become unreachable.
- Push latency: `din` sampled at edge N. `wr_ack`, `count`, `full` and `empty` reflect the push after edge N.
- Pop latency: `rd_en` sampled at edge N. `dout` and `rd_ack` are valid after edge N.
- Back-to-back pushes and pops at one per cycle are sustained. Throughput is 1 push + 1 pop per cycle when neither empty nor full.
- `full`/`empty` are derived from registered `count`, so they are glitch-free and registered.

## Configuration
- `FIFO_CTRL_THRESH_EN` defined adds two registered outputs:
  - `almost_full`: `count`≥7.
  - `almost_empty`: `count`≤1.
  - Both reset to `almost_full`=0, `almost_empty`=1, and update on the same edge as `count`.
- `FIFO_CTRL_THRESH_EN` undefined: both ports are absent. All other behaviour is identical.

## Test plan
- Reset, then idle 2 cycles → `empty`=1, `full`=0, `data_count`=0, `dout`=0, no ack/err.
- Push 0x11111111..0x88888888 on 8 consecutive cycles, then push 0xDEADBEEF:
  - `wr_ack` for the first 8 pushes, `full`=1, `data_count`=8.
  - The 9th push gives `wr_err`=1 and `rf_we`=0.
- From full, pop 9 times:
  - `dout` sequence 0x11111111..0x88888888 with `rd_ack` each.
  - 9th pop gives `rd_err`=1, `dout` holds 0x88888888, `empty`=1.
- Wrap-around: push 5, pop 5, then push 6 → `tail` wraps past 7 to 3, and pops return the 6 values in order.
- Simultaneous push and pop:
  - At `count`=4: `wr_ack` and `rd_ack` both 1, count stays 4.
  - At `count`=0: `wr_ack`=1, `rd_err`=1, count becomes 1.
  - At `count`=8: `rd_ack`=1, `wr_err`=1, count becomes 7.
- Assert `reset_n` with `count`=5 while `wr_en`=1 → `rf_we`=0 that cycle. Next cycle `count`=0, `empty`=1; the next pop gives `rd_err`.

Source files
------------

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: FIFO sequencing controller over an external 8x32 register file.
// Optional FIFO_CTRL_THRESH_EN adds registered almost_full/almost_empty outputs.
// reset_n is a synchronous, active-high reset despite its name.
module fifo_ctrl (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [31:0] din,
    input  logic        rd_en,
    output logic [31:0] dout,
    output logic [3:0]  data_count,
    output logic        full,
    output logic        empty,
    output logic        wr_ack,
    output logic        wr_err,
    output logic        rd_ack,
    output logic        rd_err,
`ifdef FIFO_CTRL_THRESH_EN
    output logic        almost_full,
    output logic        almost_empty,
`endif
    output logic        rf_we,
    output logic [2:0]  rf_wAddr,
    output logic [31:0] rf_wData,
    output logic [2:0]  rf_rAddr,
    input  logic [31:0] rf_rData
);
    typedef enum logic [2:0] {IDLE, WRITE, READ, WR_RD, WR_ERR, RD_ERR} state_t;
    state_t      state_q, state_d;
    logic [2:0]  head_q, head_d, tail_q, tail_d;
    logic [3:0]  count_q, count_d;
    logic [31:0] dout_q, dout_d;
    logic        side_q, side_d;
    logic        push_ok, pop_ok;
`ifdef FIFO_CTRL_THRESH_EN
    logic        af_q, ae_q;
`endif
    // Acceptance from pre-edge count; side flags the rejected half of a mixed request
    always_comb begin
        push_ok = wr_en && (count_q < 4'd8);
        pop_ok  = rd_en && (count_q != 4'd0);
        state_d = (push_ok && pop_ok) ? WR_RD :
                  push_ok             ? WRITE :
                  pop_ok              ? READ  :
                  wr_en               ? WR_ERR :
                  rd_en               ? RD_ERR : IDLE;
        side_d  = (push_ok && rd_en && !pop_ok) || (pop_ok && wr_en && !push_ok);
        tail_d  = push_ok ? tail_q + 3'd1 : tail_q;
        head_d  = pop_ok ? head_q + 3'd1 : head_q;
        count_d = count_q + {3'd0, push_ok} - {3'd0, pop_ok};
        dout_d  = pop_ok ? rf_rData : dout_q;
    end
    // State register; reset wins over any request
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= IDLE;
            side_q  <= 1'b0;
            head_q  <= 3'd0;
            tail_q  <= 3'd0;
            count_q <= 4'd0;
            dout_q  <= 32'd0;
`ifdef FIFO_CTRL_THRESH_EN
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            side_q  <= side_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            dout_q  <= dout_d;
`ifdef FIFO_CTRL_THRESH_EN
            af_q    <= count_d >= 4'd7;
            ae_q    <= count_d <= 4'd1;
`endif
        end
    end
    // Decode registered op-state into ack/err strobes and drive the register file
    always_comb begin
        wr_ack     = (state_q == WRITE) || (state_q == WR_RD);
        rd_ack     = (state_q == READ) || (state_q == WR_RD);
        wr_err     = (state_q == WR_ERR) || (state_q == READ && side_q);
        rd_err     = (state_q == RD_ERR) || (state_q == WRITE && side_q);
        dout       = dout_q;
        data_count = count_q;
        full       = count_q == 4'd8;
        empty      = count_q == 4'd0;
        rf_we      = push_ok && !reset_n;
        rf_wAddr   = tail_q;
        rf_wData   = din;
        rf_rAddr   = head_q;
`ifdef FIFO_CTRL_THRESH_EN
        almost_full  = af_q;
        almost_empty = ae_q;
`endif
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: directed scoreboard bench for fifo_ctrl with a behavioural register file.
module tb_fifo_ctrl;
    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        wr_en = 1'b0;
    logic [31:0] din = 32'd0;
    logic        rd_en = 1'b0;
    logic [31:0] dout;
    logic [3:0]  data_count;
    logic        full, empty, wr_ack, wr_err, rd_ack, rd_err;
    logic        rf_we;
    logic [2:0]  rf_wAddr, rf_rAddr;
    logic [31:0] rf_wData, rf_rData;
`ifdef FIFO_CTRL_THRESH_EN
    logic        almost_full, almost_empty;
`endif
    logic [31:0] mem [8];
    logic [31:0] q [$];
    logic [3:0]  m_cnt = 4'd0;
    logic [2:0]  m_head = 3'd0, m_tail = 3'd0;
    logic [31:0] m_dout = 32'd0;
    int          n_chk = 0;
    int          n_fail = 0;

    fifo_ctrl dut (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .dout(dout), .data_count(data_count), .full(full), .empty(empty),
        .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err),
`ifdef FIFO_CTRL_THRESH_EN
        .almost_full(almost_full), .almost_empty(almost_empty),
`endif
        .rf_we(rf_we), .rf_wAddr(rf_wAddr), .rf_wData(rf_wData),
        .rf_rAddr(rf_rAddr), .rf_rData(rf_rData)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rf_we) mem[rf_wAddr] <= rf_wData;
    assign rf_rData = mem[rf_rAddr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic w, input logic [31:0] d, input logic r);
        logic pw, pp;
        @(negedge clk);
        reset_n = rst; wr_en = w; din = d; rd_en = r;
        pw = w && (m_cnt < 4'd8) && !rst;
        pp = r && (m_cnt != 4'd0) && !rst;
        #1;
        chk("rf_we", {31'd0, rf_we}, {31'd0, pw});
        chk("rf_wAddr", {29'd0, rf_wAddr}, {29'd0, m_tail});
        chk("rf_rAddr", {29'd0, rf_rAddr}, {29'd0, m_head});
        if (pw) chk("rf_wData", rf_wData, d);
        if (rst) begin
            q.delete(); m_cnt = 4'd0; m_head = 3'd0; m_tail = 3'd0; m_dout = 32'd0;
        end else begin
            if (pw) begin q.push_back(d); m_tail = m_tail + 3'd1; end
            if (pp) m_head = m_head + 3'd1;
            m_cnt = m_cnt + {3'd0, pw} - {3'd0, pp};
        end
        @(posedge clk);
        #1;
        chk("wr_ack", {31'd0, wr_ack}, {31'd0, pw});
        chk("wr_err", {31'd0, wr_err}, {31'd0, w && !pw && !rst});
        chk("rd_ack", {31'd0, rd_ack}, {31'd0, pp});
        chk("rd_err", {31'd0, rd_err}, {31'd0, r && !pp && !rst});
        chk("data_count", {28'd0, data_count}, {28'd0, m_cnt});
        chk("full", {31'd0, full}, {31'd0, m_cnt == 4'd8});
        chk("empty", {31'd0, empty}, {31'd0, m_cnt == 4'd0});
`ifdef FIFO_CTRL_THRESH_EN
        chk("almost_full", {31'd0, almost_full}, {31'd0, m_cnt >= 4'd7});
        chk("almost_empty", {31'd0, almost_empty}, {31'd0, m_cnt <= 4'd1});
`endif
        if (pp && q.size() > 0) m_dout = q.pop_front();
        chk("dout", dout, m_dout);
    endtask

    initial begin
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        for (int k = 1; k <= 8; k++) step(1'b0, 1'b1, 32'h11111111 * k, 1'b0);
        step(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        for (int k = 0; k < 9; k++) step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("dout_hold", dout, 32'h88888888);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, $urandom, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 32'd0, 1'b1);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, $urandom, 1'b0);
        chk("tail_wrap", {29'd0, rf_wAddr}, 32'd3);
        for (int k = 0; k < 6; k++) step(1'b0, 1'b0, 32'd0, 1'b1);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, $urandom, 1'b0);
        step(1'b0, 1'b1, 32'hA5A5A5A5, 1'b1);
        chk("cnt4_both", {28'd0, data_count}, 32'd4);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b1, 32'h0BADF00D, 1'b1);
        chk("cnt0_both", {28'd0, data_count}, 32'd1);
        for (int k = 0; k < 7; k++) step(1'b0, 1'b1, $urandom, 1'b0);
        step(1'b0, 1'b1, 32'hCAFEBABE, 1'b1);
        chk("cnt8_both", {28'd0, data_count}, 32'd7);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        chk("cnt5", {28'd0, data_count}, 32'd5);
        step(1'b1, 1'b1, 32'h12345678, 1'b0);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1, $urandom, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        step(1'b0, 1'b0, 32'd0, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
